// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0] result_d;
    logic            done_d, busy_d;

    // Operand signedness and magnitudes at launch
    logic            is_div, sgn_a, sgn_b, sa_bit, sb_bit;
    logic [XLEN-1:0] amag, bmag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_val;

    assign is_div  = funct3[2];
    assign sgn_a   = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    assign sgn_b   = is_div ? ~funct3[0] : (funct3 == 3'b001);
    assign sa_bit  = sgn_a & rs1_val[XLEN-1];
    assign sb_bit  = sgn_b & rs2_val[XLEN-1];
    assign amag    = sa_bit ? -rs1_val : rs1_val;
    assign bmag    = sb_bit ? -rs2_val : rs2_val;

    assign div_zero    = is_div && (rs2_val == '0);
    assign div_ovf     = is_div && ~funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
    assign special     = div_zero | div_ovf;
    assign special_val = div_zero ? (funct3[1] ? rs1_val : '1)
                                  : (funct3[1] ? '0 : rs1_val);

    // One iteration of each algorithm; acc holds {partial/remainder, multiplier/quotient}
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ok;
    logic [AW-1:0]   mul_next, div_next;

    assign mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[XLEN];
    assign div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ok};

    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quot, rem, fix_val;

    assign prod    = negq_q ? -acc_q : acc_q;
    assign quot    = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem     = negr_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    assign fix_val = op_q[2] ? (op_q[1] ? rem : quot)
                             : ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[AW-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
    logic [AW-1:0] fast_mag, fast_prod;
    assign fast_mag  = {{XLEN{1'b0}}, amag} * {{XLEN{1'b0}}, bmag};
    assign fast_prod = (sa_bit ^ sb_bit) ? -fast_mag : fast_mag;
`endif

    // Next-state, datapath and stall
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    stall  = 1'b1;
                    op_d   = funct3;
                    cnt_d  = CW'(XLEN - 1);
                    negq_d = sa_bit ^ sb_bit;
                    negr_d = sa_bit;
                    opnd_d = is_div ? bmag : amag;
                    acc_d  = {{XLEN{1'b0}}, (is_div ? amag : bmag)};
                    state_d = CALC;
                    if (special) begin
                        result_d = special_val;
                        state_d  = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                          : fast_prod[AW-1:XLEN];
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_val;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d == CALC) || (state_d == FIX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            result  <= result_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed, random, flush, reset and start-in-DONE scenarios.
module tb_muldiv_sequencer;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst, start, flush;
    logic [2:0]    funct3;
    logic [XL-1:0] rs1_val, rs2_val;
    logic          stall, busy, done;
    logic [XL-1:0] result;

    int n_pass  = 0;
    int n_total = 0;
    logic [XL-1:0] last_res;

    muldiv_sequencer #(.XLEN(XL)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic from the RV32M definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f3)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; end
            3'd6: begin if (b == 0) return a; p = sa % sb; end
            default: begin if (b == 0) return a; p = ua % ub; end
        endcase
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XL + 2;
    endfunction

    // Launch one op in the current (IDLE) cycle and check stall/busy/done timing and result
    task automatic test_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        exp = ref_res(f3, a, b);
        lat = ref_lat(f3, a, b);
        funct3 = f3; rs1_val = a; rs2_val = b; start = 1'b1; flush = 1'b0;
        #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL start_stall f3=%0d: got %b want 1", f3, stall);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            n_total++;
            if (done !== (k == lat)) $display("FAIL done_timing f3=%0d cyc=t+%0d: got %b want %b", f3, k, done, k == lat);
            else n_pass++;
            n_total++;
            if (stall !== (k < lat) || busy !== (k < lat))
                $display("FAIL stall_busy f3=%0d cyc=t+%0d: got %b/%b want %b", f3, k, stall, busy, k < lat);
            else n_pass++;
        end
        n_total++;
        if (result !== exp) $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, result, exp);
        else n_pass++;
        last_res = exp;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || stall !== 1'b0)
            $display("FAIL reset_state: got busy=%b done=%b result=%h stall=%b want 0", busy, done, result, stall);
        else n_pass++;
        rst = 1'b0;
        last_res = '0;
    endtask

    task automatic test_directed();
        test_op(3'd0, 32'd7,         32'hFFFF_FFFD);
        test_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        test_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        test_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        test_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        test_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        test_op(3'd5, 32'd100,       32'd7);
        test_op(3'd7, 32'd100,       32'd7);
    endtask

    task automatic test_special();
        test_op(3'd5, 32'd5,         32'd0);
        test_op(3'd6, 32'd5,         32'd0);
        test_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        test_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        test_op(3'd4, 32'hDEAD_BEEF, 32'd0);
        test_op(3'd7, 32'h1234_5678, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 32; i++)
            test_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    endtask

    task automatic test_flush();
        // flush in IDLE suppresses start
        funct3 = 3'd4; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1; flush = 1'b1;
        #1;
        n_total++;
        if (stall !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", stall);
        else n_pass++;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL flush_idle_accept: got busy=%b done=%b want 0", busy, done);
        else n_pass++;
        // DIV launched at t, flushed at t+10
        funct3 = 3'd4; rs1_val = $urandom; rs2_val = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            n_total++;
            if (done !== 1'b0 || busy !== 1'b1) $display("FAIL flush_pre: got done=%b busy=%b want 0/1", done, busy);
            else n_pass++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== last_res)
            $display("FAIL flush_abort: got busy=%b done=%b stall=%b result=%h want 0/0/0/%h",
                     busy, done, stall, result, last_res);
        else n_pass++;
        test_op(3'd4, 32'hFFFF_FF00, 32'd5);
    endtask

    task automatic test_reset_mid();
        funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || stall !== 1'b0)
            $display("FAIL reset_mid: got busy=%b done=%b result=%h stall=%b want 0", busy, done, result, stall);
        else n_pass++;
        last_res = '0;
        test_op(3'd5, 32'd1000, 32'd9);
    endtask

    task automatic test_start_in_done();
        funct3 = 3'd5; rs1_val = 32'd5; rs2_val = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b1) $display("FAIL done_first: got %b want 1", done);
        else n_pass++;
        funct3 = 3'd7; rs1_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFF_FFFF)
            $display("FAIL start_in_done: got done=%b busy=%b result=%h want 0/0/ffffffff", done, busy, result);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b0 || result !== 32'hFFFF_FFFF)
            $display("FAIL start_in_done_after: got done=%b result=%h want 0/ffffffff", done, result);
        else n_pass++;
        last_res = 32'hFFFF_FFFF;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_reset_mid();
        test_start_in_done();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle execution unit and sequencer for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the ALU in the EX stage and is launched when the control unit decodes opcode 0110011 with funct7 = 0000001. While an operation is in flight it holds the pipeline stall line high. On completion it drops the stall for exactly one cycle so that EX/MEM captures the result.

## Interface
Parameters:
- XLEN, 32, operand/result width (even, ≥8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  in  XLEN  operand A (multiplicand/dividend)
- rs2_val  in  XLEN  operand B (multiplier/divisor)
- flush  in  1  abort in-flight op (branch/jump redirect)
- stall  out  1  combinational; hold IF/ID/EX while high
- busy  out  1  registered; high in CALC and FIX
- done  out  1  registered; one-cycle pulse in DONE
- result  out  XLEN  registered; valid when done=1, held until next accepted start

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1 and flush=0: latch funct3 and operands, convert each to its magnitude according to signedness, record the result sign, and load the counter with XLEN-1.
  - Signed operands: MULH both; MULHSU rs1 only; DIV/REM both. All other operands are unsigned.
  - Next state is CALC, except for the special cases below, which go straight to DONE.
- Special cases go IDLE→DONE with the result computed at start:
  - DIV/DIVU by 0: result all-ones.
  - REM/REMU by 0: result = rs1_val.
  - DIV of most-negative by -1: result = rs1_val.
  - REM of most-negative by -1: result = 0.
- CALC runs one iteration per cycle; the counter decrements and the last iteration is at counter 0, after which the next state is FIX.
  - Multiply: shift-add into a 2·XLEN accumulator, LSB of the multiplier first.
  - Divide: restoring division, MSB of the dividend first, producing one quotient bit per cycle.
- FIX:
  - Multiply: negate the product if the recorded sign is negative.
  - Quotient: negative when the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Selection: MUL → product[XLEN-1:0]; MULH* → product[2·XLEN-1:XLEN]; DIV* → quotient; REM* → remainder.
  - Write the selection to result; next state is DONE.
- DONE: done=1; next state is IDLE unconditionally. A start in DONE is ignored, and the requester re-presents it in IDLE.
- Output logic:
  - stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX.
  - busy = state ∈ {CALC, FIX}.
- flush has priority over everything except rst. In CALC or FIX it forces IDLE next cycle with no done and result unchanged. In IDLE it suppresses start. In DONE it has no effect, because the op has already retired.
- start while not in IDLE is ignored.

## Timing
- Reset: state=IDLE, counter=0, result=0, done=0, busy=0. stall follows its combinational equation (low unless start is asserted).
- rst mid-operation returns all state to these reset values at the next edge; no done is issued.
- Iterative latency, with start accepted in cycle t:
  - CALC occupies t+1…t+XLEN.
  - FIX occupies t+XLEN+1.
  - DONE (done=1, stall=0) occurs in t+XLEN+2, i.e. t+34 for XLEN=32.
- Special cases: done in t+1.
- stall is high from cycle t through t+XLEN+1 inclusive.
- Back-to-back: the earliest next start is accepted in t+XLEN+3 (IDLE).

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU compute a combinational 2·XLEN signed/unsigned product in the start cycle and go IDLE→DONE, with done in t+1.
  - Divide path unchanged.
- Undefined: all multiplies use the iterative CALC/FIX path with latency XLEN+2.

## Test plan
- MUL 7 × 0xFFFFFFFD at t → result 0xFFFFFFEB, done at t+34 (t+1 with MULDIV_FAST_MUL_EN), stall high t…t+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2; all with done at t+34.
- Special cases, each with done at t+1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- DIV started at t, flush at t+10:
  - IDLE at t+11; no done pulse; result keeps its previous value.
  - New start at t+11 completes at t+45.
- rst at t+20 mid-DIV: at t+21 all outputs are at reset values (result=0); no done; start at t+21 is accepted normally.
